// File: rtl/maxpool_2x2_if.sv
// Pixel stream interface for the 2x2 max-pooling stage: convolution pixels in,
// pooled pixels with their pooled coordinates and an end-of-frame pulse out.
interface maxpool_2x2_if #(
    parameter int WORD_SIZE  = 8,
    parameter int ROW_SIZE   = 538,
    parameter int FRAME_ROWS = 538
);
    localparam int COL_W = (ROW_SIZE / 2 > 1) ? $clog2(ROW_SIZE / 2) : 1;
    localparam int ROW_W = (FRAME_ROWS / 2 > 1) ? $clog2(FRAME_ROWS / 2) : 1;

    logic [WORD_SIZE-1:0] in_pixel;
    logic                 in_valid;
    logic [WORD_SIZE-1:0] out_pixel;
    logic                 out_valid;
    logic [COL_W-1:0]     out_col;
    logic [ROW_W-1:0]     out_row;
    logic                 frame_done;

    modport master (
        output in_pixel, in_valid,
        input  out_pixel, out_valid, out_col, out_row, frame_done
    );

    modport slave (
        input  in_pixel, in_valid,
        output out_pixel, out_valid, out_col, out_row, frame_done
    );
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling. Even rows park pair maxima in a
// half-width line buffer; odd rows combine them and emit one pooled pixel.
module maxpool_2x2 #(
    parameter int WORD_SIZE  = 8,
    parameter int ROW_SIZE   = 538,
    parameter int FRAME_ROWS = 538
) (
    input logic           clk,
    input logic           rst,
    maxpool_2x2_if.slave  pif
);
    localparam int COL_W = (ROW_SIZE / 2 > 1) ? $clog2(ROW_SIZE / 2) : 1;
    localparam int ROW_W = (FRAME_ROWS / 2 > 1) ? $clog2(FRAME_ROWS / 2) : 1;
    // One extra bit below the pooled index gives the full input position
    localparam int CW = COL_W + 1;
    localparam int RW = ROW_W + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
    localparam int LB_DEPTH = ROW_SIZE / 2;

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WORD_SIZE-1:0] pair_q, pair_d;
    logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
    logic                 out_valid_q, out_valid_d;
    logic [COL_W-1:0]     out_col_q, out_col_d;
    logic [ROW_W-1:0]     out_row_q, out_row_d;
    logic                 frame_done_q, frame_done_d;

    logic [WORD_SIZE-1:0] line_buf_q [LB_DEPTH];

    logic [COL_W-1:0]     col_idx;
    logic [ROW_W-1:0]     row_idx;
    logic [WORD_SIZE-1:0] pair_max;
    logic [WORD_SIZE-1:0] lb_rd;
    logic                 lb_we;

    assign col_idx  = col_q[CW-1:1];
    assign row_idx  = row_q[RW-1:1];
    assign pair_max = (pif.in_pixel > pair_q) ? pif.in_pixel : pair_q;
    assign lb_rd    = line_buf_q[col_idx];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_pixel_d  = out_pixel_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (pif.in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                pair_d = pif.in_pixel;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_pixel_d  = (lb_rd > pair_max) ? lb_rd : pair_max;
                out_col_d    = col_idx;
                out_row_d    = row_idx;
                out_valid_d  = 1'b1;
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_pixel_q  <= '0;
            out_valid_q  <= 1'b0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_pixel_q  <= out_pixel_d;
            out_valid_q  <= out_valid_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer is never reset; every entry is rewritten on an even row before use
    always_ff @(posedge clk) begin
        if (!rst && lb_we) begin
            line_buf_q[col_idx] <= pair_max;
        end
    end

    assign pif.out_pixel  = out_pixel_q;
    assign pif.out_valid  = out_valid_q;
    assign pif.out_col    = out_col_q;
    assign pif.out_row    = out_row_q;
    assign pif.frame_done = frame_done_q;
endmodule
